phys_reg_free_list: RTL

- Checkpointed circular FIFO of free physical register tags, sitting between dispatch and the ROB/BRU.
- Dispatch dequeues a fresh dest tag per renamed reg-writing instr.
- ROB commit enqueues the freed safe tag. ROB revert pushes a speculated tag back to the head.
- BRU checkpoints save and restore the head pointer so a mispredict recovers the list in one cycle.

---
 rtl/phys_reg_free_list.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/phys_reg_free_list.sv
// Checkpointed circular free list of physical register tags.
// Dispatch takes tags from the head, commit returns them at the tail,
// ROB revert pushes a speculated tag back to the head, and up to
// CHECKPOINT_COLUMNS saved head pointers allow one-cycle mispredict recovery.
// Optional macro FREE_LIST_BYPASS_EN: an empty list forwards a same-cycle
// enqueued tag straight to the dequeue port.
//
// Handshake: a transfer on a valid/ready pair happens on the rising CLK edge
// where valid=1 and ready=1; ready never depends on the matching valid,
// except that in the bypass build dequeue_ready may follow enqueue_valid.
module phys_reg_free_list #(
  parameter int NUM_PHYS_REGS      = 64,
  parameter int NUM_ARCH_REGS      = 32,
  parameter int CHECKPOINT_COLUMNS = 4,
  localparam int PHYS_REG_WIDTH    = $clog2(NUM_PHYS_REGS),
  localparam int FREE_LIST_DEPTH   = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int AW                = $clog2(FREE_LIST_DEPTH),
  localparam int PW                = AW + 1,
  localparam int CW                = $clog2(CHECKPOINT_COLUMNS)
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      dequeue_valid,
  output logic                      dequeue_ready,
  output logic [PHYS_REG_WIDTH-1:0] dequeue_phys_reg_tag,
  input  logic                      enqueue_valid,
  input  logic [PHYS_REG_WIDTH-1:0] enqueue_phys_reg_tag,
  input  logic                      revert_valid,
  input  logic [PHYS_REG_WIDTH-1:0] revert_phys_reg_tag,
  input  logic                      save_checkpoint_valid,
  output logic                      save_checkpoint_ready,
  output logic [CW-1:0]             save_checkpoint_column,
  input  logic                      restore_checkpoint_valid,
  input  logic [CW-1:0]             restore_checkpoint_column,
  input  logic                      clear_checkpoint_valid,
  input  logic [CW-1:0]             clear_checkpoint_column,
  output logic [PW-1:0]             free_count
);

  logic [PHYS_REG_WIDTH-1:0] entries_q [FREE_LIST_DEPTH];
  logic [PW-1:0]             head_q, head_d;
  logic [PW-1:0]             tail_q, tail_d;
  logic [CHECKPOINT_COLUMNS-1:0] ckpt_valid_q, ckpt_valid_d;
  logic [PW-1:0]             ckpt_head_q [CHECKPOINT_COLUMNS];
  logic [PW-1:0]             ckpt_head_d [CHECKPOINT_COLUMNS];
  logic [CW-1:0]             alloc_q, alloc_d;

  logic          empty, full;
  logic          do_deq, do_enq, do_revert, do_save, do_restore;
  logic [PW-1:0] head_m1;
  logic [CW-1:0] span, off;

  assign free_count = tail_q - head_q;
  assign empty      = (free_count == '0);
  assign full       = (free_count == PW'(FREE_LIST_DEPTH));
  assign head_m1    = head_q - PW'(1);

  // Head tag and ready; the bypass build forwards an enqueue into an empty list.
  always_comb begin
`ifdef FREE_LIST_BYPASS_EN
    dequeue_ready        = !empty || enqueue_valid;
    dequeue_phys_reg_tag = empty ? enqueue_phys_reg_tag : entries_q[head_q[AW-1:0]];
`else
    dequeue_ready        = !empty;
    dequeue_phys_reg_tag = entries_q[head_q[AW-1:0]];
`endif
  end

  assign save_checkpoint_ready  = !ckpt_valid_q[alloc_q];
  assign save_checkpoint_column = alloc_q;

  // Operation qualification: restore beats revert, revert beats dequeue.
  always_comb begin
    do_restore = restore_checkpoint_valid && ckpt_valid_q[restore_checkpoint_column];
    do_enq     = enqueue_valid && !full;
    do_revert  = revert_valid && !full && !do_restore;
    do_deq     = dequeue_valid && dequeue_ready && !revert_valid && !do_restore;
    do_save    = save_checkpoint_valid && save_checkpoint_ready && !do_restore;
  end

  // Next-state for pointers and checkpoint columns.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    ckpt_valid_d = ckpt_valid_q;
    alloc_d      = alloc_q;
    span         = alloc_q - restore_checkpoint_column;
    off          = '0;
    for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
      ckpt_head_d[i] = ckpt_head_q[i];
    end

    if (do_enq)    tail_d = tail_q + PW'(1);
    if (do_revert) head_d = head_m1;
    else if (do_deq) head_d = head_q + PW'(1);

    if (clear_checkpoint_valid) ckpt_valid_d[clear_checkpoint_column] = 1'b0;

    if (do_save) begin
      ckpt_valid_d[alloc_q] = 1'b1;
      ckpt_head_d[alloc_q]  = head_d;
      alloc_d               = alloc_q + CW'(1);
    end

    // Restore drops the restored column and every younger one; a span of
    // zero means the allocator wrapped onto this column, so all are younger.
    if (do_restore) begin
      head_d = ckpt_head_q[restore_checkpoint_column];
      for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
        off = CW'(i) - restore_checkpoint_column;
        if (span == '0 || off < span) ckpt_valid_d[i] = 1'b0;
      end
      alloc_d = restore_checkpoint_column + CW'(1);
    end
  end

  // State registers; reset fills the list with the non-architectural tags.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
        entries_q[i] <= PHYS_REG_WIDTH'(NUM_ARCH_REGS + i);
      end
      for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
        ckpt_head_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= PW'(FREE_LIST_DEPTH);
      ckpt_valid_q <= '0;
      alloc_q      <= '0;
    end else begin
      if (do_enq)    entries_q[tail_q[AW-1:0]]  <= enqueue_phys_reg_tag;
      if (do_revert) entries_q[head_m1[AW-1:0]] <= revert_phys_reg_tag;
      for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
        ckpt_head_q[i] <= ckpt_head_d[i];
      end
      head_q       <= head_d;
      tail_q       <= tail_d;
      ckpt_valid_q <= ckpt_valid_d;
      alloc_q      <= alloc_d;
    end
  end

endmodule
